commit_trace_serializer: RTL and testbench

Serializes the core's dual-lane retirement stream into the single-entry, pulse-per-record stream the testbench trace logger consumes. Sits between the commit stage (two instructions may retire per cycle, lane 0 older) and the trace logger, which samples one record per rising edge of its valid input. It buffers retired records in a FIFO and replays them strictly in program order. Each valid pulse is followed by a guaranteed low gap, so every record produces a distinct rising edge.

---
 rtl/commit_trace_serializer.sv | 160 ++++++++++++++++
 tb/tb_commit_trace_serializer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_serializer.sv
// Dual-lane retirement to single-record trace stream: FIFO buffers commits in program order,
// an emit FSM replays one record per pulse followed by a guaranteed low gap.
module commit_trace_serializer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  commit_valid_i,
  input  logic [63:0] commit_pc_i,
  input  logic [63:0] commit_instr_i,
  input  logic [9:0]  commit_rd_i,
  input  logic [63:0] commit_rd_data_i,
  input  logic [1:0]  commit_is_load_i,
  input  logic [1:0]  commit_is_store_i,
  input  logic [1:0]  commit_is_float_i,
  input  logic [3:0]  commit_mem_size_i,
  input  logic [63:0] commit_mem_addr_i,
  input  logic [63:0] commit_mem_data_i,
  input  logic [9:0]  commit_fflags_i,
  output logic        ready_o,
  output logic        overflow_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        is_float_o,
  output logic [1:0]  mem_size_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [31:0] fpu_flags_o,
  output logic [31:0] emitted_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        is_load;
    logic        is_store;
    logic        is_float;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [4:0]  fflags;
  } rec_t;

  typedef enum logic [1:0] {StIdle, StEmit, StGap} state_e;

  rec_t              lane_rec [2];
  rec_t              mem_q [DEPTH];
  rec_t              rec_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d, n_push;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [31:0]       emitted_q;
  logic              overflow_q;
  state_e            state_q, state_d;
  logic              rdy, accept, pop;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      lane_rec[l].pc       = commit_pc_i[32*l +: 32];
      lane_rec[l].instr    = commit_instr_i[32*l +: 32];
      lane_rec[l].rd       = commit_rd_i[5*l +: 5];
      lane_rec[l].rd_data  = commit_rd_data_i[32*l +: 32];
      lane_rec[l].is_load  = commit_is_load_i[l];
      lane_rec[l].is_store = commit_is_store_i[l];
      lane_rec[l].is_float = commit_is_float_i[l];
      lane_rec[l].mem_size = commit_mem_size_i[2*l +: 2];
      lane_rec[l].mem_addr = commit_mem_addr_i[32*l +: 32];
      lane_rec[l].mem_data = commit_mem_data_i[32*l +: 32];
      lane_rec[l].fflags   = commit_fflags_i[5*l +: 5];
    end
  end

  // Two free slots guarantee a whole dual-lane group fits; a same-cycle pop is not credited.
  assign rdy     = rst_ni && (count_q <= CntW'(DEPTH - 2));
  assign accept  = rdy && (|commit_valid_i);
  assign n_push  = accept ? (CntW'(commit_valid_i[0]) + CntW'(commit_valid_i[1])) : '0;
  assign pop     = (count_q != '0) &&
                   ((state_q == StIdle) || ((state_q == StGap) && (gap_q == '0)));
  assign count_d = count_q + n_push - CntW'(pop);

  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (commit_valid_i[0]) mem_q[wr_ptr_q] <= lane_rec[0];
      if (commit_valid_i[1]) begin
        mem_q[commit_valid_i[0] ? wr_ptr_q + PtrW'(1) : wr_ptr_q] <= lane_rec[1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: if (pop) state_d = StEmit;
      StEmit: begin
        state_d = StGap;
        gap_d   = GapW'(GAP_CYCLES - 1);
      end
      StGap: begin
        // Last gap cycle chains straight into the next pop to keep a 1+GAP_CYCLES period.
        if (gap_q == '0) state_d = pop ? StEmit : StIdle;
        else             gap_d   = gap_q - GapW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      gap_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rec_q      <= '0;
      emitted_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_q + PtrW'(n_push);
      overflow_q <= overflow_q | ((|commit_valid_i) & ~rdy);
      if (pop) begin
        rec_q     <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + PtrW'(1);
        emitted_q <= emitted_q + 32'd1;
      end
    end
  end

  assign ready_o       = rdy;
  assign overflow_o    = overflow_q;
  assign valid_o       = (state_q == StEmit);
  assign pc_o          = rec_q.pc;
  assign instr_o       = rec_q.instr;
  assign reg_addr_o    = rec_q.rd;
  assign reg_data_o    = rec_q.rd_data;
  assign is_load_o     = rec_q.is_load;
  assign is_store_o    = rec_q.is_store;
  assign is_float_o    = rec_q.is_float;
  assign mem_size_o    = rec_q.mem_size;
  assign mem_addr_o    = rec_q.mem_addr;
  assign mem_data_o    = rec_q.mem_data;
  assign fpu_flags_o   = {27'b0, rec_q.fflags};
  assign emitted_cnt_o = emitted_q;

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Bench: queue/cooldown reference model checked every cycle, plus directed literal checks,
// and a GAP_CYCLES=3 instance checked for pulse spacing and field hold.
module tb_commit_trace_serializer;

  localparam int unsigned Depth = 8;
  localparam int unsigned Gap   = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cv = '0;
  logic [63:0] cpc = '0, cinstr = '0, crdata = '0, caddr = '0, cmdata = '0;
  logic [9:0]  crd = '0, cff = '0;
  logic [1:0]  cld = '0, cst = '0, cfl = '0;
  logic [3:0]  csize = '0;

  logic        ready, ovf, valid, ld, st, fl;
  logic [31:0] pc, instr, rdata, maddr, mdata, fpu, ecnt;
  logic [4:0]  rd;
  logic [1:0]  msize;

  logic        ready3, ovf3, valid3, ld3, st3, fl3;
  logic [31:0] pc3, instr3, rdata3, maddr3, mdata3, fpu3, ecnt3;
  logic [4:0]  rd3;
  logic [1:0]  msize3;

  commit_trace_serializer #(.DEPTH(Depth), .GAP_CYCLES(Gap)) dut (
    .clk_i(clk), .rst_ni(rst_n), .commit_valid_i(cv), .commit_pc_i(cpc),
    .commit_instr_i(cinstr), .commit_rd_i(crd), .commit_rd_data_i(crdata),
    .commit_is_load_i(cld), .commit_is_store_i(cst), .commit_is_float_i(cfl),
    .commit_mem_size_i(csize), .commit_mem_addr_i(caddr), .commit_mem_data_i(cmdata),
    .commit_fflags_i(cff), .ready_o(ready), .overflow_o(ovf), .valid_o(valid), .pc_o(pc),
    .instr_o(instr), .reg_addr_o(rd), .reg_data_o(rdata), .is_load_o(ld), .is_store_o(st),
    .is_float_o(fl), .mem_size_o(msize), .mem_addr_o(maddr), .mem_data_o(mdata),
    .fpu_flags_o(fpu), .emitted_cnt_o(ecnt)
  );

  commit_trace_serializer #(.DEPTH(8), .GAP_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .commit_valid_i(cv), .commit_pc_i(cpc),
    .commit_instr_i(cinstr), .commit_rd_i(crd), .commit_rd_data_i(crdata),
    .commit_is_load_i(cld), .commit_is_store_i(cst), .commit_is_float_i(cfl),
    .commit_mem_size_i(csize), .commit_mem_addr_i(caddr), .commit_mem_data_i(cmdata),
    .commit_fflags_i(cff), .ready_o(ready3), .overflow_o(ovf3), .valid_o(valid3),
    .pc_o(pc3), .instr_o(instr3), .reg_addr_o(rd3), .reg_data_o(rdata3), .is_load_o(ld3),
    .is_store_o(st3), .is_float_o(fl3), .mem_size_o(msize3), .mem_addr_o(maddr3),
    .mem_data_o(mdata3), .fpu_flags_o(fpu3), .emitted_cnt_o(ecnt3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, data, addr, md;
    logic [4:0]  rd, ff;
    logic        ld, st, fl;
    logic [1:0]  sz;
  } rec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: pending records in a queue, emitter cooldown in cycles.
  rec_t  q[$];
  rec_t  m_rec = '{default: '0};
  logic  m_valid = 1'b0;
  logic  m_ovf = 1'b0;
  int    m_cnt = 0;
  int    busy = 0;

  logic        cap = 1'b0;
  logic [31:0] seen_pc[$];
  logic        g3_phase = 1'b0;
  int          g3_n = 0;
  int          g3_last_cyc = 0;
  logic [31:0] g3_last_pc = '0;
  logic [31:0] g3_exp[3] = '{32'h300, 32'h304, 32'h308};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rec_t lane(input int l);
    rec_t r;
    r.pc = cpc[l*32 +: 32];     r.instr = cinstr[l*32 +: 32];
    r.rd = crd[l*5 +: 5];       r.data  = crdata[l*32 +: 32];
    r.ld = cld[l];              r.st = cst[l];            r.fl = cfl[l];
    r.sz = csize[l*2 +: 2];     r.addr = caddr[l*32 +: 32];
    r.md = cmdata[l*32 +: 32];  r.ff = cff[l*5 +: 5];
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete(); busy = 0; m_valid = 1'b0; m_ovf = 1'b0; m_cnt = 0;
      m_rec = '{default: '0};
    end else begin
      int  old_size;
      old_size = q.size();
      m_valid = 1'b0;
      if (busy > 0) busy--;
      else if (old_size > 0) begin
        m_rec = q.pop_front(); m_valid = 1'b1; m_cnt++; busy = Gap;
      end
      if (cv != 2'b00) begin
        if (old_size <= Depth - 2) begin
          if (cv[0]) q.push_back(lane(0));
          if (cv[1]) q.push_back(lane(1));
        end else m_ovf = 1'b1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    chk("valid", 32'(valid), 32'(m_valid));
    chk("ready", 32'(ready), 32'(rst_n && (q.size() <= Depth - 2)));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("emitted_cnt", ecnt, m_cnt);
    chk("pc", pc, m_rec.pc);
    chk("instr", instr, m_rec.instr);
    chk("reg_addr", 32'(rd), 32'(m_rec.rd));
    chk("reg_data", rdata, m_rec.data);
    chk("class", {29'b0, ld, st, fl}, {29'b0, m_rec.ld, m_rec.st, m_rec.fl});
    chk("mem_size", 32'(msize), 32'(m_rec.sz));
    chk("mem_addr", maddr, m_rec.addr);
    chk("mem_data", mdata, m_rec.md);
    chk("fpu_flags", fpu, {27'b0, m_rec.ff});
    if (cap && valid) seen_pc.push_back(pc);
    if (g3_phase) begin
      if (valid3) begin
        if (g3_n > 0) chk("g3_spacing", cyc - g3_last_cyc, 4);
        if (g3_n < 3) chk("g3_pc", pc3, g3_exp[g3_n]);
        g3_last_cyc = cyc; g3_last_pc = pc3; g3_n++;
      end else if (g3_n > 0) begin
        chk("g3_hold", pc3, g3_last_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [31:0] p, input logic [31:0] ins,
                          input logic [4:0] r, input logic [31:0] d, input logic [2:0] cls,
                          input logic [1:0] sz, input logic [31:0] a, input logic [31:0] m,
                          input logic [4:0] f);
    cpc[l*32 +: 32] = p;     cinstr[l*32 +: 32] = ins;
    crd[l*5 +: 5] = r;       crdata[l*32 +: 32] = d;
    cld[l] = cls[0];         cst[l] = cls[1];          cfl[l] = cls[2];
    csize[l*2 +: 2] = sz;    caddr[l*32 +: 32] = a;
    cmdata[l*32 +: 32] = m;  cff[l*5 +: 5] = f;
  endtask

  task automatic clear();
    cv = '0; cpc = '0; cinstr = '0; crd = '0; crdata = '0; cld = '0; cst = '0; cfl = '0;
    csize = '0; caddr = '0; cmdata = '0; cff = '0;
  endtask

  initial begin
    logic [31:0] exp_pc[$];
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(ready), 1);
    chk("rst_cnt", ecnt, 0);

    // Single lane-0 commit: pulse right after edge N+1.
    set_lane(0, 32'h8000_0000, 32'h0050_0093, 5'd1, 32'd5, 3'b000, 2'b10, 0, 0, 0);
    cv = 2'b01;
    tick();
    clear();
    tick();
    chk("t1_valid", 32'(valid), 1);
    chk("t1_pc", pc, 32'h8000_0000);
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_rd", 32'(rd), 1);
    chk("t1_data", rdata, 5);
    chk("t1_fpu", fpu, 0);
    chk("t1_cnt", ecnt, 1);
    repeat (4) tick();

    // Dual commit: pulses at N+1 and N+3 with a low cycle between.
    set_lane(0, 32'h100, 32'h1111, 5'd2, 32'd7, 3'b100, 2'b00, 0, 0, 5'h01);
    set_lane(1, 32'h104, 32'h2222, 5'd3, 32'd9, 3'b001, 2'b10, 32'h40, 0, 5'h11);
    cv = 2'b11;
    tick();
    clear();
    tick();
    chk("t2_valid0", 32'(valid), 1);
    chk("t2_pc0", pc, 32'h100);
    tick();
    chk("t2_gap_valid", 32'(valid), 0);
    chk("t2_gap_pc", pc, 32'h100);
    tick();
    chk("t2_valid1", 32'(valid), 1);
    chk("t2_pc1", pc, 32'h104);
    chk("t2_fpu1", fpu, 32'h11);
    chk("t2_cnt", ecnt, 3);
    repeat (4) tick();

    // Lane-1-only store.
    set_lane(1, 32'h200, 32'h00f1_1023, 5'd0, 0, 3'b010, 2'b01, 32'h2000, 32'hBEEF, 0);
    cv = 2'b10;
    tick();
    clear();
    tick();
    chk("t3_valid", 32'(valid), 1);
    chk("t3_store", 32'(st), 1);
    chk("t3_size", 32'(msize), 1);
    chk("t3_addr", maddr, 32'h2000);
    chk("t3_mdata", mdata, 32'h0000_BEEF);
    chk("t3_pc", pc, 32'h200);
    repeat (6) tick();
    chk("t3_cnt", ecnt, 4);

    // Sustained dual retirement: fill, throttle, drop.
    seen_pc.delete();
    cap = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_lane(0, 32'h1000 + 32'(8 * i), 32'h10 + 32'(i), 5'd4, 32'(i), 0, 0, 0, 0, 0);
      set_lane(1, 32'h1004 + 32'(8 * i), 32'h20 + 32'(i), 5'd5, 32'(i), 0, 0, 0, 0, 0);
      cv = 2'b11;
      tick();
      if (i == 3) chk("t4_ready_hi", 32'(ready), 1);
      if (i == 4) begin
        chk("t4_ready_lo", 32'(ready), 0);
        chk("t4_ovf_lo", 32'(ovf), 0);
      end
      if (i == 5) chk("t4_ovf_hi", 32'(ovf), 1);
    end
    clear();
    repeat (40) tick();
    cap = 1'b0;
    for (int k = 0; k < 10; k++) exp_pc.push_back(32'h1000 + 32'(4 * k));
    exp_pc.push_back(32'h1040);
    exp_pc.push_back(32'h1044);
    chk("t4_n_records", seen_pc.size(), exp_pc.size());
    for (int k = 0; k < exp_pc.size() && k < seen_pc.size(); k++) chk("t4_seq", seen_pc[k], exp_pc[k]);
    chk("t4_ovf_sticky", 32'(ovf), 1);

    // Reset mid-GAP with 5 entries queued.
    for (int i = 0; i < 3; i++) begin
      set_lane(0, 32'h3000 + 32'(8 * i), 32'h77, 5'd6, 32'h55, 0, 0, 0, 0, 0);
      set_lane(1, 32'h3004 + 32'(8 * i), 32'h78, 5'd7, 32'h66, 0, 0, 0, 0, 0);
      cv = 2'b11;
      tick();
    end
    clear();
    chk("t5_pre_valid", 32'(valid), 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(valid), 0);
    chk("t5_rst_pc", pc, 0);
    chk("t5_rst_cnt", ecnt, 0);
    chk("t5_rst_ovf", 32'(ovf), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("t5_no_pulse_cnt", ecnt, 0);
    set_lane(0, 32'h4000, 32'h99, 5'd8, 32'h1, 0, 0, 0, 0, 0);
    cv = 2'b01;
    tick();
    clear();
    tick();
    chk("t5_new_valid", 32'(valid), 1);
    chk("t5_new_pc", pc, 32'h4000);
    chk("t5_new_cnt", ecnt, 1);
    repeat (3) tick();

    // GAP_CYCLES=3 instance: three records spaced four cycles apart.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    g3_phase = 1'b1;
    set_lane(0, 32'h300, 32'hA0, 5'd9, 32'h3, 0, 0, 0, 0, 0);
    set_lane(1, 32'h304, 32'hA4, 5'd10, 32'h4, 0, 0, 0, 0, 0);
    cv = 2'b11;
    tick();
    clear();
    set_lane(0, 32'h308, 32'hA8, 5'd11, 32'h5, 0, 0, 0, 0, 0);
    cv = 2'b01;
    tick();
    clear();
    repeat (16) tick();
    g3_phase = 1'b0;
    chk("g3_n_records", g3_n, 3);
    chk("g3_cnt", ecnt3, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
